robertson_control: RTL and testbench

Sequencing FSM for the Robertson signed shift-add multiplier datapath. On `start` it clears the accumulator, loads multiplicand and multiplier into their `register` instances, then steps through N add/subtract-and-shift iterations. Each step is chosen by the current multiplier LSB. It sits between the top-level handshake and the datapath registers and adder/subtractor. It owns every load, clear and shift strobe; the datapath owns the data.

---
 rtl/robertson_control.sv | 93 +++++++++
 tb/tb_robertson_control.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/robertson_control.sv
// Sequencing FSM for a Robertson signed shift-add multiplier.
// Emits the load/clear/shift strobes and add/subtract selection for an N-bit datapath.
module robertson_control #(
    parameter int N = 8,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          q_lsb,
    output logic          clear_a,
    output logic          load_m,
    output logic          load_q,
    output logic          load_a,
    output logic          sub,
    output logic          shift,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        OP,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state, state_next;
    logic   last_step;

    assign last_step = (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs; comb blocks use blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (state == LOAD) begin
                count <= '0;
            end else if (state == SHIFT && !last_step) begin
                count <= count + 1'b1;
            end
        end
    end

    // NOTE: every comb output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = OP;
            OP:      state_next = SHIFT;
            SHIFT:   state_next = last_step ? DONE : OP;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        clear_a = 1'b0;
        load_m  = 1'b0;
        load_q  = 1'b0;
        load_a  = 1'b0;
        sub     = 1'b0;
        shift   = 1'b0;
        done    = 1'b0;
        busy    = (state != IDLE);
        case (state)
            LOAD: begin
                clear_a = 1'b1;
                load_m  = 1'b1;
                load_q  = 1'b1;
            end
            OP: begin
                // The multiplier sign bit carries negative weight, so the final step subtracts.
                load_a = q_lsb;
                sub    = q_lsb & last_step;
            end
            SHIFT:   shift = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_robertson_control.sv
// Directed bench for robertson_control with a behavioural Robertson datapath
// driven by the DUT strobes, so full products can be checked.
module tb_robertson_control;

    localparam int N  = 8;
    localparam int CW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          q_lsb;
    logic          clear_a, load_m, load_q, load_a, sub, shift, busy, done;
    logic [CW-1:0] count;

    logic [N-1:0] op_m, op_q;
    logic [N-1:0] dp_m, dp_a, dp_q;
    logic         dp_f;
    logic [N:0]   dp_sum;

    int passes = 0;
    int total  = 0;

    robertson_control #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .q_lsb  (q_lsb),
        .clear_a(clear_a),
        .load_m (load_m),
        .load_q (load_q),
        .load_a (load_a),
        .sub    (sub),
        .shift  (shift),
        .count  (count),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Datapath model: F:A accumulator, M multiplicand, Q multiplier/product-low.
    assign q_lsb  = dp_q[0];
    assign dp_sum = sub ? ({dp_a[N-1], dp_a} - {dp_m[N-1], dp_m})
                        : ({dp_a[N-1], dp_a} + {dp_m[N-1], dp_m});

    always @(posedge clk) begin
        if (clear_a) begin
            dp_a <= '0;
            dp_f <= 1'b0;
        end
        if (load_m) dp_m <= op_m;
        if (load_q) dp_q <= op_q;
        if (load_a) begin
            dp_f <= dp_sum[N];
            dp_a <= dp_sum[N-1:0];
        end
        if (shift) begin
            dp_a <= {dp_f, dp_a[N-1:1]};
            dp_q <= {dp_a[0], dp_q[N-1:1]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] outs();
        return {clear_a, load_m, load_q, load_a, sub, shift, busy, done};
    endfunction

    // One multiply: pulse start, watch every cycle up to done, then check the log.
    task automatic run_mult(input string tag, input logic [N-1:0] m, input logic [N-1:0] q,
                            input logic [N-1:0] exp_la, input logic [N-1:0] exp_sub,
                            input logic [2*N-1:0] exp_prod, input bit poke_start);
        logic [N-1:0]  la_mask, sub_mask;
        int            loads, shifts, bad_excl, bad_busy, done_at;
        logic [CW-1:0] done_count;
        la_mask = '0; sub_mask = '0;
        loads = 0; shifts = 0; bad_excl = 0; bad_busy = 0; done_at = 0; done_count = '0;
        op_m  = m;
        op_q  = q;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (clear_a && load_m && load_q) loads++;
            if (load_a) la_mask[count] = 1'b1;
            if (sub) sub_mask[count] = 1'b1;
            if (sub && !load_a) bad_excl++;
            if ((int'(load_a) + int'(shift) + int'(clear_a)) > 1) bad_excl++;
            if (shift) shifts++;
            if (!busy) bad_busy++;
            if (done) begin
                done_at    = n;
                done_count = count;
                break;
            end
            start = poke_start && (count == 3) && !clear_a;
            tick();
        end
        start = 1'b0;
        chk({tag, " done_latency"}, done_at, 2 * N + 2);
        chk({tag, " load_cycles"}, loads, 1);
        chk({tag, " load_a_steps"}, la_mask, exp_la);
        chk({tag, " sub_steps"}, sub_mask, exp_sub);
        chk({tag, " shift_count"}, shifts, N);
        chk({tag, " exclusive"}, bad_excl, 0);
        chk({tag, " busy_held"}, bad_busy, 0);
        chk({tag, " count_at_done"}, done_count, N - 1);
        chk({tag, " product"}, {dp_a, dp_q}, exp_prod);
        tick();
        chk({tag, " idle_after"}, outs(), 8'h00);
    endtask

    initial begin
        int            guard;
        logic [7:0]    seen;
        reset = 1'b1;
        start = 1'b1;
        op_m  = '0;
        op_q  = '0;

        // Reset with start held high: FSM must stay idle.
        tick();
        chk("reset_outs_1", outs(), 8'h00);
        chk("reset_count_1", count, 0);
        tick();
        chk("reset_outs_2", outs(), 8'h00);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_no_start", outs(), 8'h00);

        run_mult("q5", 8'd3, 8'b0000_0101, 8'b0000_0101, 8'h00, 16'h000F, 1'b0);
        run_mult("sign", 8'd5, 8'b1000_0000, 8'b1000_0000, 8'b1000_0000, 16'hFD80, 1'b0);
        run_mult("m3q5", 8'hFD, 8'd5, 8'b0000_0101, 8'h00, 16'hFFF1, 1'b0);
        run_mult("min", 8'h80, 8'h80, 8'b1000_0000, 8'b1000_0000, 16'h4000, 1'b0);
        run_mult("zero", 8'h00, 8'hFF, 8'hFF, 8'b1000_0000, 16'h0000, 1'b0);
        run_mult("poke", 8'd7, 8'd6, 8'b0000_0110, 8'h00, 16'h002A, 1'b1);

        // Start held high: back-to-back runs with one idle cycle between.
        op_m  = 8'd2;
        op_q  = 8'd3;
        start = 1'b1;
        tick();
        chk("b2b_load", clear_a, 1'b1);
        repeat (2 * N + 1) tick();
        chk("b2b_done", done, 1'b1);
        tick();
        chk("b2b_idle", busy, 1'b0);
        tick();
        chk("b2b_reload", {clear_a, load_m, load_q}, 3'b111);
        start = 1'b0;

        // Abort in SHIFT at count 4 with a synchronous reset.
        guard = 0;
        while (!(shift && count == 4) && guard < 40) begin
            tick();
            guard++;
        end
        chk("abort_reached", {shift, count}, {1'b1, 3'd4});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_outs", outs(), 8'h00);
        chk("abort_count", count, 0);
        seen = '0;
        repeat (4) begin
            tick();
            seen = seen | outs();
        end
        chk("abort_quiet", seen, 8'h00);

        run_mult("after_abort", 8'hFD, 8'd5, 8'b0000_0101, 8'h00, 16'hFFF1, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
